// File: rtl/accum_block_looper_multi.sv
// Walks an N_DIM nested loop of block offsets and broadcasts every offset to N_CH
// rdy/ack consumers through a shared ring buffer with one read pointer per channel.
module accum_block_looper_multi #(
    parameter int N_CH   = 5,
    parameter int N_DIM  = 4,
    parameter int DIM_BW = 16,
    parameter int DEPTH  = 4
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         src_rdy,
    output logic                         src_ack,
    input  logic [N_DIM*DIM_BW-1:0]      src_bbeg,
    input  logic [N_DIM*DIM_BW-1:0]      src_bend,
    input  logic [N_DIM*DIM_BW-1:0]      src_bstride,
    input  logic [N_CH-1:0]              src_chmask,
    output logic [N_CH-1:0]              dst_rdy,
    input  logic [N_CH-1:0]              dst_ack,
    output logic [N_CH*N_DIM*DIM_BW-1:0] dst_abofs,
    output logic [N_CH-1:0]              dst_last,
    output logic                         busy
);

    localparam int VW = N_DIM * DIM_BW;
    localparam int PW = $clog2(DEPTH);
    localparam int OW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [VW-1:0]   r_bbeg;
    logic [VW-1:0]   r_bend;
    logic [VW-1:0]   r_bstride;
    logic [N_CH-1:0] r_chmask;
    logic [VW-1:0]   r_cnt;
    logic [VW-1:0]   w_cnt_nxt;
    logic            w_final;

    logic [VW-1:0]   r_ofs  [DEPTH];
    logic [N_CH-1:0] r_pend [DEPTH];
    logic [DEPTH-1:0] r_wr;
    logic [DEPTH-1:0] r_last;
    logic [PW-1:0]   r_wp;
    logic [PW-1:0]   r_hp;
    logic [PW-1:0]   r_rp [N_CH];
    logic [OW-1:0]   r_occ;
    logic [OW-1:0]   w_occ_nxt;

    logic            w_accept;
    logic            w_empty_cmd;
    logic            w_wr;
    logic            w_free;
    logic [N_CH-1:0] w_rdy;
    logic [N_CH-1:0] w_take;

    assign w_accept  = (r_state == S_IDLE) && src_rdy && !i_rst;
    assign src_ack   = w_accept;
    assign busy      = (r_state != S_IDLE);
    assign w_wr      = (r_state == S_RUN) && (r_occ < OW'(DEPTH));
    assign w_free    = r_wr[r_hp] && (r_pend[r_hp] == '0);
    assign w_occ_nxt = r_occ + OW'(w_wr) - OW'(w_free);

    always_comb begin
        w_empty_cmd = (src_chmask == '0);
        for (int d = 0; d < N_DIM; d++) begin
            if (src_bbeg[d*DIM_BW +: DIM_BW] >= src_bend[d*DIM_BW +: DIM_BW]) begin
                w_empty_cmd = 1'b1;
            end
        end
    end

    // Odometer step; a carry out of DIM_BW bits counts as reaching the end.
    always_comb begin
        logic [DIM_BW:0] v_sum;
        logic            v_carry;
        v_sum     = '0;
        v_carry   = 1'b1;
        w_cnt_nxt = r_cnt;
        for (int d = N_DIM - 1; d >= 0; d--) begin
            if (v_carry) begin
                v_sum = {1'b0, r_cnt[d*DIM_BW +: DIM_BW]} + {1'b0, r_bstride[d*DIM_BW +: DIM_BW]};
                if (v_sum[DIM_BW] || (v_sum[DIM_BW-1:0] >= r_bend[d*DIM_BW +: DIM_BW])) begin
                    w_cnt_nxt[d*DIM_BW +: DIM_BW] = r_bbeg[d*DIM_BW +: DIM_BW];
                end else begin
                    w_cnt_nxt[d*DIM_BW +: DIM_BW] = v_sum[DIM_BW-1:0];
                    v_carry = 1'b0;
                end
            end
        end
        w_final = v_carry;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_accept && !w_empty_cmd) w_state_nxt = S_RUN;
            S_RUN:   if (w_wr && w_final) w_state_nxt = S_DRAIN;
            S_DRAIN: if (w_occ_nxt == '0) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Payload is forced to zero whenever a channel is not presenting an entry.
    always_comb begin
        w_rdy     = '0;
        w_take    = '0;
        dst_last  = '0;
        dst_abofs = '0;
        for (int c = 0; c < N_CH; c++) begin
            w_rdy[c] = r_wr[r_rp[c]] && r_pend[r_rp[c]][c];
            if (w_rdy[c]) begin
                dst_abofs[c*VW +: VW] = r_ofs[r_rp[c]];
                dst_last[c]           = r_last[r_rp[c]];
            end
            w_take[c] = w_rdy[c] && dst_ack[c];
        end
    end

    assign dst_rdy = w_rdy;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_occ   <= '0;
            r_wp    <= '0;
            r_hp    <= '0;
            r_wr    <= '0;
            for (int c = 0; c < N_CH; c++) r_rp[c] <= '0;
            for (int e = 0; e < DEPTH; e++) r_pend[e] <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_occ   <= w_occ_nxt;
            if (w_accept) begin
                r_wp <= '0;
                r_hp <= '0;
                for (int c = 0; c < N_CH; c++) r_rp[c] <= '0;
            end else begin
                if (w_wr)   r_wp <= r_wp + PW'(1);
                if (w_free) r_hp <= r_hp + PW'(1);
                for (int c = 0; c < N_CH; c++) begin
                    if (w_take[c]) r_rp[c] <= r_rp[c] + PW'(1);
                end
            end
            if (w_wr) begin
                r_wr[r_wp]   <= 1'b1;
                r_pend[r_wp] <= r_chmask;
            end
            if (w_free) r_wr[r_hp] <= 1'b0;
            for (int c = 0; c < N_CH; c++) begin
                if (w_take[c]) r_pend[r_rp[c]][c] <= 1'b0;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_accept) begin
            r_bbeg    <= src_bbeg;
            r_bend    <= src_bend;
            r_bstride <= src_bstride;
            r_chmask  <= src_chmask;
            r_cnt     <= src_bbeg;
        end else if (w_wr) begin
            r_cnt <= w_cnt_nxt;
        end
        if (w_wr) begin
            r_ofs[r_wp]  <= r_cnt;
            r_last[r_wp] <= w_final;
        end
    end

endmodule

// File: tb/tb_accum_block_looper_multi.sv
// Bench for accum_block_looper_multi: directed vector table, hand-written corner
// sequences and randomized commands checked against a nested-loop reference.
module tb_accum_block_looper_multi;

    localparam int N_CH   = 5;
    localparam int N_DIM  = 2;
    localparam int DIM_BW = 16;
    localparam int DEPTH  = 4;
    localparam int VW     = N_DIM * DIM_BW;

    logic                 i_clk = 1'b0;
    logic                 i_rst;
    logic                 src_rdy;
    logic                 src_ack;
    logic [VW-1:0]        src_bbeg;
    logic [VW-1:0]        src_bend;
    logic [VW-1:0]        src_bstride;
    logic [N_CH-1:0]      src_chmask;
    logic [N_CH-1:0]      dst_rdy;
    logic [N_CH-1:0]      dst_ack;
    logic [N_CH*VW-1:0]   dst_abofs;
    logic [N_CH-1:0]      dst_last;
    logic                 busy;

    always #5 i_clk = ~i_clk;

    accum_block_looper_multi #(
        .N_CH(N_CH), .N_DIM(N_DIM), .DIM_BW(DIM_BW), .DEPTH(DEPTH)
    ) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .src_rdy(src_rdy), .src_ack(src_ack),
        .src_bbeg(src_bbeg), .src_bend(src_bend), .src_bstride(src_bstride),
        .src_chmask(src_chmask),
        .dst_rdy(dst_rdy), .dst_ack(dst_ack), .dst_abofs(dst_abofs),
        .dst_last(dst_last), .busy(busy)
    );

    typedef struct {
        logic [15:0] b0, b1, e0, e1, s0, s1;
        logic [4:0]  m;
        int          cnt;
        logic [31:0] last_ofs;
        bit          busy_exp;
    } vec_t;

    vec_t        vecs [8];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_ofs [64];
    int          exp_n;
    int          got_n [N_CH];
    int          got_last_n [N_CH];
    logic [31:0] got_last_ofs [N_CH];
    int          first_edge [N_CH];
    int          last_edge [N_CH];
    int          acc_edge, fall_edge, snap1;
    bit          busy_after_acc;

    task automatic chk_eq(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: plain nested loops over the offset space; dim1 is innermost.
    task automatic build_model(input logic [15:0] b0, b1, e0, e1, s0, s1);
        exp_n = 0;
        for (int a = int'(b0); a < int'(e0); a += int'(s0)) begin
            for (int b = int'(b1); b < int'(e1); b += int'(s1)) begin
                if (exp_n < 64) exp_ofs[exp_n] = {b[15:0], a[15:0]};
                exp_n++;
            end
        end
    endtask

    // Called at posedge+1; returns at posedge+1 after the command has fully drained.
    task automatic run_cmd(input logic [15:0] b0, b1, e0, e1, s0, s1,
                           input logic [4:0] m, input int low_pct, input int hold0);
        int cyc;
        int hi;
        int lo;
        bit acc;
        bit done;
        bit take_src;
        logic [31:0] act_v;
        build_model(b0, b1, e0, e1, s0, s1);
        for (int c = 0; c < N_CH; c++) begin
            got_n[c] = 0; got_last_n[c] = 0; got_last_ofs[c] = '0;
            first_edge[c] = -1; last_edge[c] = -1;
        end
        acc_edge = -1; fall_edge = -1; snap1 = -1; busy_after_acc = 1'b0;
        src_bbeg = {b1, b0}; src_bend = {e1, e0}; src_bstride = {s1, s0};
        src_chmask = m; src_rdy = 1'b1;
        acc = 1'b0; done = 1'b0; cyc = 0;
        while (!done && cyc < 4000) begin
            #1;
            take_src = src_rdy && src_ack;
            chk_eq("masked_rdy", 64'(dst_rdy & ~m), 64'(0));
            for (int c = 0; c < N_CH; c++) begin
                dst_ack[c] = dst_rdy[c] && !(c == 0 && cyc < hold0)
                             && (int'($urandom_range(99)) >= low_pct);
                if (dst_ack[c]) begin
                    act_v = dst_abofs[c*VW +: VW];
                    if (got_n[c] < exp_n && got_n[c] < 64) begin
                        chk_eq($sformatf("ofs ch%0d #%0d", c, got_n[c]), 64'(act_v), 64'(exp_ofs[got_n[c]]));
                        chk_eq($sformatf("last ch%0d #%0d", c, got_n[c]), 64'(dst_last[c]),
                               64'(got_n[c] == exp_n - 1));
                    end else begin
                        chk_eq($sformatf("extra_xfer ch%0d", c), 64'(got_n[c] + 1), 64'(exp_n));
                    end
                    if (dst_last[c]) begin
                        got_last_n[c]++;
                        got_last_ofs[c] = act_v;
                    end
                    if (first_edge[c] < 0) first_edge[c] = cyc;
                    last_edge[c] = cyc;
                    got_n[c]++;
                end
            end
            if (cyc == hold0) snap1 = got_n[1];
            if (m != '0) begin
                hi = 0; lo = 1 << 30;
                for (int c = 0; c < N_CH; c++) begin
                    if (m[c]) begin
                        if (got_n[c] > hi) hi = got_n[c];
                        if (got_n[c] < lo) lo = got_n[c];
                    end
                end
                chk_eq("ahead_within_depth", 64'((hi - lo) <= DEPTH), 64'(1));
            end
            @(posedge i_clk);
            #1;
            dst_ack = '0;
            if (take_src) begin
                src_rdy = 1'b0; acc = 1'b1; acc_edge = cyc; busy_after_acc = busy;
            end else if (acc && !busy) begin
                fall_edge = cyc; done = 1'b1;
            end
            cyc++;
        end
        if (!done) begin
            chk_eq("timeout", 64'(0), 64'(1));
            src_rdy = 1'b0;
            i_rst = 1'b1;
            @(posedge i_clk);
            #1;
            i_rst = 1'b0;
        end
        for (int c = 0; c < N_CH; c++) begin
            chk_eq($sformatf("count ch%0d", c), 64'(got_n[c]), 64'(m[c] ? exp_n : 0));
            chk_eq($sformatf("lastflags ch%0d", c), 64'(got_last_n[c]), 64'((m[c] && exp_n > 0) ? 1 : 0));
        end
        chk_eq("busy_after_accept", 64'(busy_after_acc), 64'(m != '0 && exp_n > 0));
    endtask

    initial begin
        logic [15:0] b0, b1, e0, e1, s0, s1;
        logic [4:0]  m;

        vecs[0] = '{16'd0, 16'd0, 16'd2, 16'd3, 16'd1, 16'd1, 5'h1F, 6, 32'h0002_0001, 1'b1};
        vecs[1] = '{16'd0, 16'd0, 16'd1, 16'd10, 16'd1, 16'd4, 5'h1F, 3, 32'h0008_0000, 1'b1};
        vecs[2] = '{16'd0, 16'hFFF0, 16'd2, 16'hFFFF, 16'd1, 16'h20, 5'h1F, 2, 32'hFFF0_0001, 1'b1};
        vecs[3] = '{16'd0, 16'd0, 16'd2, 16'd2, 16'd1, 16'd1, 5'h05, 4, 32'h0001_0001, 1'b1};
        vecs[4] = '{16'd1, 16'd0, 16'd1, 16'd5, 16'd1, 16'd1, 5'h1F, 0, 32'h0, 1'b0};
        vecs[5] = '{16'd0, 16'd0, 16'd2, 16'd3, 16'd1, 16'd1, 5'h00, 0, 32'h0, 1'b0};
        vecs[6] = '{16'd3, 16'd0, 16'd2, 16'd5, 16'd1, 16'd1, 5'h1F, 0, 32'h0, 1'b0};
        vecs[7] = '{16'd5, 16'd7, 16'd9, 16'd20, 16'd3, 16'd5, 5'h1A, 6, 32'h0011_0008, 1'b1};

        i_rst = 1'b1; src_rdy = 1'b0; dst_ack = '0;
        src_bbeg = '0; src_bend = '0; src_bstride = '0; src_chmask = '0;
        repeat (2) @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        chk_eq("rst src_ack", 64'(src_ack), 64'(0));
        chk_eq("rst dst_rdy", 64'(dst_rdy), 64'(0));
        chk_eq("rst dst_last", 64'(dst_last), 64'(0));
        chk_eq("rst busy", 64'(busy), 64'(0));
        chk_eq("rst dst_abofs_nonzero", 64'(dst_abofs != '0), 64'(0));

        for (int i = 0; i < 8; i++) begin
            run_cmd(vecs[i].b0, vecs[i].b1, vecs[i].e0, vecs[i].e1, vecs[i].s0, vecs[i].s1,
                    vecs[i].m, 0, 0);
            for (int c = 0; c < N_CH; c++) begin
                if (vecs[i].m[c]) begin
                    chk_eq($sformatf("tbl%0d cnt ch%0d", i, c), 64'(got_n[c]), 64'(vecs[i].cnt));
                    if (vecs[i].cnt > 0)
                        chk_eq($sformatf("tbl%0d last_ofs ch%0d", i, c), 64'(got_last_ofs[c]),
                               64'(vecs[i].last_ofs));
                end
            end
            chk_eq($sformatf("tbl%0d busy", i), 64'(busy_after_acc), 64'(vecs[i].busy_exp));
            if (i == 0) begin
                for (int c = 0; c < N_CH; c++) begin
                    chk_eq($sformatf("first_latency ch%0d", c), 64'(first_edge[c]), 64'(acc_edge + 2));
                    chk_eq($sformatf("back_to_back ch%0d", c), 64'(last_edge[c] - first_edge[c]), 64'(5));
                end
                chk_eq("busy_fall", 64'(fall_edge), 64'(last_edge[0] + 1));
            end
        end

        // Channel 0 stalled: the others may only run DEPTH offsets ahead.
        run_cmd(16'd0, 16'd0, 16'd3, 16'd3, 16'd1, 16'd1, 5'h1F, 0, 20);
        chk_eq("stall_depth ch1", 64'(snap1), 64'(DEPTH));

        // Reset mid-RUN with three buffered entries.
        src_bbeg = {16'd0, 16'd0}; src_bend = {16'd4, 16'd4}; src_bstride = {16'd1, 16'd1};
        src_chmask = 5'h1F; src_rdy = 1'b1; dst_ack = '0;
        @(posedge i_clk);
        #1;
        src_rdy = 1'b0;
        repeat (3) @(posedge i_clk);
        #1;
        chk_eq("pre_rst busy", 64'(busy), 64'(1));
        chk_eq("pre_rst dst_rdy", 64'(dst_rdy), 64'(5'h1F));
        i_rst = 1'b1;
        @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        chk_eq("mid_rst dst_rdy", 64'(dst_rdy), 64'(0));
        chk_eq("mid_rst busy", 64'(busy), 64'(0));
        chk_eq("mid_rst dst_last", 64'(dst_last), 64'(0));
        run_cmd(16'd2, 16'd1, 16'd3, 16'd3, 16'd1, 16'd1, 5'h1F, 0, 0);
        chk_eq("post_rst last_ofs", 64'(got_last_ofs[0]), 64'(32'h0002_0002));

        for (int k = 0; k < 200; k++) begin
            b0 = 16'($urandom_range(3));
            e0 = b0 + 16'($urandom_range(3));
            s0 = 16'($urandom_range(2, 1));
            if ($urandom_range(4) == 0) begin
                b1 = 16'hFFE0 + 16'($urandom_range(16));
                e1 = 16'hFFE8 + 16'($urandom_range(23));
                s1 = 16'($urandom_range(32, 4));
            end else begin
                b1 = 16'($urandom_range(7));
                e1 = b1 + 16'($urandom_range(12));
                s1 = 16'($urandom_range(4, 1));
            end
            m = 5'($urandom_range(31));
            run_cmd(b0, b1, e0, e1, s0, s1, m, 30, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/accum_block_looper_multi.md
Name: accum_block_looper_multi

Overview:
Parametrised successor to the single-config accumulation block looper. Accepts one accumulation-block command, walks an N_DIM nested loop of block offsets (begin, end, stride per dimension), and broadcasts every offset to N_CH independent rdy/ack consumers (input, DMA, output and ALU stages). A shared ring buffer lets fast channels run up to DEPTH offsets ahead of slow ones. A per-command channel mask skips unused consumers.

Parameters:
N_CH, 5, number of destination channels
N_DIM, 4, loop dimensions; dimension N_DIM-1 is innermost
DIM_BW, 16, bits per offset component
DEPTH, 4, ring-buffer entries (power of 2, >=2)

Ports:
i_clk  in  1  clock
i_rst  in  1  synchronous, active-high reset
src_rdy  in  1  command valid
src_ack  out  1  command accepted
src_bbeg  in  N_DIM*DIM_BW  loop begin per dimension
src_bend  in  N_DIM*DIM_BW  loop end (exclusive) per dimension
src_bstride  in  N_DIM*DIM_BW  loop stride per dimension (nonzero)
src_chmask  in  N_CH  enabled channels
dst_rdy  out  N_CH  per-channel offset valid
dst_ack  in  N_CH  per-channel accept; asserted only while the matching dst_rdy is high
dst_abofs  out  N_CH*N_DIM*DIM_BW  per-channel block offset
dst_last  out  N_CH  final offset of the command for that channel
busy  out  1  command in progress

Behaviour:
- Handshake: rdy stays high until the ack cycle. Payload is stable while rdy is high. Transfer happens when rdy && ack at a clock edge.
- Reset: one clock edge with i_rst high clears all state. Outputs after reset: src_ack=0, dst_rdy=0, dst_last=0, busy=0, dst_abofs=0. Reset mid-command discards the command and all buffered entries.
- FSM IDLE -> RUN -> DRAIN -> IDLE.
- IDLE:
  - src_ack = src_rdy (combinational, IDLE only). On ack, latch the config.
  - Empty command: any dimension with bbeg >= bend, or chmask == 0. An empty command stays in IDLE with no dst traffic.
  - Otherwise load the counter with bbeg and go to RUN.
- RUN:
  - Each cycle with occupancy < DEPTH at cycle start, write the current offset to the tail. Tag it with pending mask = chmask and last flag = final iteration.
  - Advance the counter like an odometer. Innermost component += stride, computed in DIM_BW+1 bits. If the sum is >= bend, or carries out of DIM_BW, reset that component to bbeg and carry into the next-outer dimension.
  - After the final iteration is written, go to DRAIN.
- Full: a write is blocked whenever occupancy == DEPTH at cycle start, even if the head frees in the same cycle. There is no bypass.
- Channels:
  - Each channel has its own read pointer. dst_rdy[c] = (entry at read pointer is written) && pending[c] set.
  - On ack, clear pending[c] for that entry and advance the pointer.
  - Disabled channels never assert rdy.
- Free: when the head entry's pending mask is all zero, pop it (occupancy -1) at that edge. A free and a write in the same cycle leave occupancy unchanged.
- Latency: src ack at edge T. First write at edge T+1. dst_rdy is high in the cycle after T+1. With all acks tied high and DEPTH >= 2, throughput is one offset per cycle.
- DRAIN: when occupancy reaches 0, go to IDLE. busy = RUN || DRAIN. A new command is acked no earlier than the first IDLE cycle.
- dst_last[c] mirrors the last flag of the entry presented to channel c.

Test Plan:
1. N_DIM=2, bbeg={0,0}, bend={2,3}, stride={1,1}, chmask=all, acks tied high -> every channel sees (0,0),(0,1),(0,2),(1,0),(1,1),(1,2) on consecutive cycles; dst_last only on (1,2); busy falls 1 cycle after the last ack.
2. Channel 0 ack held low, others acking -> the other channels advance exactly DEPTH=4 offsets then stall. Releasing ack0 drains in order with no loss or duplication.
3. Stride 4, bbeg=0, bend=10 on the innermost dimension -> offsets 0,4,8 then carry. A wrap with bbeg=0xFFF0, stride 0x20, bend=0xFFFF -> carry-out treated as end; no 16-bit wraparound offset is emitted.
4. chmask=5'b00101 -> only channels 0 and 2 assert rdy; entries free with no acks on the masked channels. bend==bbeg in any dimension, or chmask=0 -> src_ack pulses, no dst_rdy, busy stays 0.
5. Random per-channel ack stalls (30% low), 200 commands -> per-channel sequences match the reference model, and occupancy never exceeds DEPTH.
6. i_rst asserted mid-RUN with 3 buffered entries -> next cycle all dst_rdy=0, busy=0. A fresh command afterwards starts from its own bbeg.
